// File: rtl/axis_ad5791_frame_rx.sv
// Passive AD5791 SPI frame receiver: oversamples SCLK/SYNC/lanes in a_clk, returns DAC writes as
// left-aligned AXI-Stream words. Define AD5791_RX_FRAME_COUNTERS_EN to build frame/err counters.
module axis_ad5791_frame_rx #(
  parameter int unsigned NUM_DAC           = 4,
  parameter int unsigned DAC_DATA_WIDTH    = 20,
  parameter int unsigned DAC_WORD_WIDTH    = 24,
  parameter int unsigned MAXIS_TDATA_WIDTH = 32,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                                a_clk,
  input  logic                                reset,
  input  logic                                wire_PMD_clk,
  input  logic                                wire_PMD_sync,
  input  logic [NUM_DAC-1:0]                  wire_PMD_dac,
  output logic [MAXIS_TDATA_WIDTH-1:0]        M_AXIS1_tdata,
  output logic                                M_AXIS1_tvalid,
  input  logic                                M_AXIS1_tready,
  output logic [MAXIS_TDATA_WIDTH-1:0]        M_AXIS2_tdata,
  output logic                                M_AXIS2_tvalid,
  input  logic                                M_AXIS2_tready,
  output logic [MAXIS_TDATA_WIDTH-1:0]        M_AXIS3_tdata,
  output logic                                M_AXIS3_tvalid,
  input  logic                                M_AXIS3_tready,
  output logic [MAXIS_TDATA_WIDTH-1:0]        M_AXIS4_tdata,
  output logic                                M_AXIS4_tvalid,
  input  logic                                M_AXIS4_tready,
  output logic [NUM_DAC*DAC_WORD_WIDTH-1:0]   cfg_word,
  output logic                                cfg_valid,
  output logic                                frame_err,
  output logic                                overrun,
  input  logic                                err_clear,
  output logic [31:0]                         frame_count,
  output logic [31:0]                         err_count
);

  localparam int unsigned BusW = NUM_DAC + 2;
  localparam int unsigned Pad  = MAXIS_TDATA_WIDTH - DAC_DATA_WIDTH;
  localparam logic [BusW-1:0] BusRst = {{NUM_DAC{1'b0}}, 1'b1, 1'b0};

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StClose = 2'd3;

  // Bus bit 0 = SCLK, bit 1 = SYNC, upper bits = lanes; one chain keeps them aligned.
  logic [BusW-1:0] sync_chain [SYNC_STAGES];
  logic [BusW-1:0] bus_last, bus_prev;
  logic [SYNC_STAGES:0] flush;
  logic flushed, sclk_fall, sync_fall, sync_rise, sync_lvl;
  logic [NUM_DAC-1:0] lanes;

  always_ff @(posedge a_clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= BusRst;
      bus_prev <= BusRst;
      flush    <= '0;
    end else begin
      sync_chain[0] <= {wire_PMD_dac, wire_PMD_sync, wire_PMD_clk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
      bus_prev <= bus_last;
      flush    <= {flush[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Reset values in the chain are not real bus state; wait until they have been flushed out.
  assign flushed   = flush[SYNC_STAGES];
  assign bus_last  = sync_chain[SYNC_STAGES-1];
  assign sclk_fall = bus_prev[0] & ~bus_last[0];
  assign sync_fall = bus_prev[1] & ~bus_last[1];
  assign sync_rise = ~bus_prev[1] & bus_last[1];
  assign sync_lvl  = bus_last[1];
  assign lanes     = bus_last[BusW-1:2];

  logic [1:0] state;
  logic       armed;
  logic [5:0] bit_cnt;
  logic [DAC_WORD_WIDTH-1:0] shreg [NUM_DAC];

  always_ff @(posedge a_clk) begin
    if (reset) begin
      state   <= StIdle;
      armed   <= 1'b0;
      bit_cnt <= '0;
      for (int i = 0; i < NUM_DAC; i++) shreg[i] <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (flushed && sync_lvl) begin
            armed <= 1'b1;
            state <= StArmed;
          end
        end
        StArmed: begin
          if (armed && sync_fall) begin
            bit_cnt <= '0;
            for (int i = 0; i < NUM_DAC; i++) shreg[i] <= '0;
            state <= StShift;
          end
        end
        StShift: begin
          if (sync_rise) begin
            state <= StClose;
          end else if (sclk_fall && !sync_lvl) begin
            if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
            for (int i = 0; i < NUM_DAC; i++) begin
              shreg[i] <= {shreg[i][DAC_WORD_WIDTH-2:0], lanes[i]};
            end
          end
        end
        StClose: state <= StArmed;
        default: state <= StIdle;
      endcase
    end
  end

  function automatic logic is_dac_write(input logic [DAC_WORD_WIDTH-1:0] w);
    return !w[DAC_WORD_WIDTH-1] && (w[DAC_WORD_WIDTH-2 -: 3] == 3'b001);
  endfunction

  logic frame_good, frame_bad, overrun_set;
  logic [NUM_DAC-1:0] dac_load, cfg_load, tvalid_r, tready_v;
  logic [3:0] tready_all;
  logic [MAXIS_TDATA_WIDTH-1:0] tdata_r [NUM_DAC];
  logic [DAC_WORD_WIDTH-1:0]    cfg_r [NUM_DAC];

  assign frame_good = (state == StClose) && (bit_cnt == 6'(DAC_WORD_WIDTH));
  assign frame_bad  = (state == StClose) && (bit_cnt != 6'(DAC_WORD_WIDTH));
  assign tready_all = {M_AXIS4_tready, M_AXIS3_tready, M_AXIS2_tready, M_AXIS1_tready};
  assign tready_v   = tready_all[NUM_DAC-1:0];

  always_comb begin
    dac_load = '0;
    cfg_load = '0;
    for (int i = 0; i < NUM_DAC; i++) begin
      dac_load[i] = frame_good && is_dac_write(shreg[i]);
      cfg_load[i] = frame_good && !is_dac_write(shreg[i]);
    end
  end

  // Overwrite of an unaccepted word; a same-cycle accept makes the reload legal.
  assign overrun_set = |(dac_load & tvalid_r & ~tready_v);

  always_ff @(posedge a_clk) begin
    if (reset) begin
      tvalid_r <= '0;
      for (int i = 0; i < NUM_DAC; i++) begin
        tdata_r[i] <= '0;
        cfg_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DAC; i++) begin
        if (dac_load[i]) begin
          tdata_r[i]  <= {shreg[i][DAC_DATA_WIDTH-1:0], {Pad{1'b0}}};
          tvalid_r[i] <= 1'b1;
        end else if (tvalid_r[i] && tready_v[i]) begin
          tvalid_r[i] <= 1'b0;
        end
        if (cfg_load[i]) cfg_r[i] <= shreg[i];
      end
    end
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cfg_valid <= |cfg_load;
      if (frame_bad)      frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (overrun_set)    overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;
    end
  end

`ifdef AD5791_RX_FRAME_COUNTERS_EN
  always_ff @(posedge a_clk) begin
    if (reset) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (frame_good) frame_count <= frame_count + 32'd1;
      if (frame_bad)  err_count   <= err_count + 32'd1;
    end
  end
`else
  assign frame_count = '0;
  assign err_count   = '0;
`endif

  logic [MAXIS_TDATA_WIDTH-1:0] tdata_all [4];
  logic [3:0] tvalid_all;

  always_comb begin
    tvalid_all = '0;
    cfg_word   = '0;
    for (int i = 0; i < 4; i++) tdata_all[i] = '0;
    for (int i = 0; i < NUM_DAC; i++) begin
      tdata_all[i]  = tdata_r[i];
      tvalid_all[i] = tvalid_r[i];
      cfg_word[i*DAC_WORD_WIDTH +: DAC_WORD_WIDTH] = cfg_r[i];
    end
  end

  assign M_AXIS1_tdata  = tdata_all[0];
  assign M_AXIS2_tdata  = tdata_all[1];
  assign M_AXIS3_tdata  = tdata_all[2];
  assign M_AXIS4_tdata  = tdata_all[3];
  assign M_AXIS1_tvalid = tvalid_all[0];
  assign M_AXIS2_tvalid = tvalid_all[1];
  assign M_AXIS3_tvalid = tvalid_all[2];
  assign M_AXIS4_tvalid = tvalid_all[3];

endmodule

// File: tb/tb_axis_ad5791_frame_rx.sv
// Scoreboard bench for axis_ad5791_frame_rx: a frame-level model queues expected stream words and
// config snapshots; a monitor pops them on every accept / cfg_valid pulse.
module tb_axis_ad5791_frame_rx;
  localparam int NL = 4;
`ifdef AD5791_RX_FRAME_COUNTERS_EN
  localparam bit CountersEn = 1'b1;
`else
  localparam bit CountersEn = 1'b0;
`endif

  logic a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  logic reset, sclk, syncn, err_clear;
  logic [NL-1:0] dac, tvalid, tready;
  logic [31:0] tdata [NL];
  logic [95:0] cfg_word;
  logic cfg_valid, frame_err, overrun;
  logic [31:0] frame_count, err_count;

  axis_ad5791_frame_rx dut (
    .a_clk(a_clk), .reset(reset),
    .wire_PMD_clk(sclk), .wire_PMD_sync(syncn), .wire_PMD_dac(dac),
    .M_AXIS1_tdata(tdata[0]), .M_AXIS1_tvalid(tvalid[0]), .M_AXIS1_tready(tready[0]),
    .M_AXIS2_tdata(tdata[1]), .M_AXIS2_tvalid(tvalid[1]), .M_AXIS2_tready(tready[1]),
    .M_AXIS3_tdata(tdata[2]), .M_AXIS3_tvalid(tvalid[2]), .M_AXIS3_tready(tready[2]),
    .M_AXIS4_tdata(tdata[3]), .M_AXIS4_tvalid(tvalid[3]), .M_AXIS4_tready(tready[3]),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .frame_err(frame_err), .overrun(overrun),
    .err_clear(err_clear), .frame_count(frame_count), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_q [NL][$];
  logic [95:0] cfg_q [$];
  logic [23:0] exp_cfg [NL];
  bit exp_ferr, exp_ovr;
  int unsigned exp_fc, exp_ec;
  int tr_mode;  // 0 random ready, 1 ready held low, 2 ready held high

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      exp_q[l].delete();
      exp_cfg[l] = '0;
    end
    cfg_q.delete();
    exp_ferr = 0; exp_ovr = 0; exp_fc = 0; exp_ec = 0;
  endtask

  task automatic model_frame(input logic [23:0] w [NL], input int nbits);
    bit any_cfg = 0;
    if (nbits != 24) begin
      exp_ferr = 1;
      exp_ec++;
    end else begin
      exp_fc++;
      for (int l = 0; l < NL; l++) begin
        if (w[l][23:20] == 4'b0001) begin
          // Ready held low: the pending word is replaced, not queued behind.
          if (tr_mode == 1 && exp_q[l].size() > 0) begin
            void'(exp_q[l].pop_back());
            exp_ovr = 1;
          end
          exp_q[l].push_back((32'(w[l]) & 32'h000F_FFFF) << 12);
        end else begin
          exp_cfg[l] = w[l];
          any_cfg = 1;
        end
      end
      if (any_cfg) cfg_q.push_back({exp_cfg[3], exp_cfg[2], exp_cfg[1], exp_cfg[0]});
    end
  endtask

  always @(posedge a_clk) begin
    #1;
    for (int l = 0; l < NL; l++)
      tready[l] = (tr_mode == 2) ? 1'b1 : (tr_mode == 1) ? 1'b0 : 1'($urandom % 2);
  end

  always @(negedge a_clk) begin
    if (!reset) begin
      for (int l = 0; l < NL; l++) begin
        if (tvalid[l] && tready[l]) begin
          if (exp_q[l].size() == 0) check($sformatf("unexpected_tdata%0d", l), tdata[l], 96'hX);
          else check($sformatf("tdata%0d", l), tdata[l], exp_q[l].pop_front());
        end
      end
      if (cfg_valid) begin
        if (cfg_q.size() == 0) check("unexpected_cfg_valid", cfg_word, 96'hX);
        else check("cfg_word", cfg_word, cfg_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge a_clk);
    #2;
  endtask

  // Drives bits [first, first+count) of each lane MSB-first, SCLK = a_clk/4.
  task automatic drive_bits(input logic [23:0] w [NL], input int first, input int count);
    for (int b = first; b < first + count; b++) begin
      for (int l = 0; l < NL; l++) dac[l] = (b < 24) ? w[l][23 - b] : 1'b0;
      sclk = 1'b1;
      tick(2);
      sclk = 1'b0;
      tick(2);
    end
  endtask

  task automatic send(input logic [23:0] w [NL], input int nbits);
    model_frame(w, nbits);
    syncn = 1'b0;
    tick(2);
    drive_bits(w, 0, nbits);
    syncn = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_frame_err"}, frame_err, exp_ferr);
    check({tag, "_overrun"}, overrun, exp_ovr);
    check({tag, "_frame_count"}, frame_count, CountersEn ? exp_fc : 0);
    check({tag, "_err_count"}, err_count, CountersEn ? exp_ec : 0);
    check({tag, "_drained"}, exp_q[0].size() + exp_q[1].size() + exp_q[2].size()
          + exp_q[3].size() + cfg_q.size(), 0);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    exp_ferr = 0;
    exp_ovr = 0;
    @(negedge a_clk);
  endtask

  logic [23:0] w [NL];

  initial begin
    reset = 1'b1; sclk = 1'b0; syncn = 1'b1; dac = '0; err_clear = 1'b0; tr_mode = 2;
    model_reset();
    tick(4);
    @(negedge a_clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata0", tdata[0], 0);
    check("rst_cfg_word", cfg_word, 0);
    check("rst_cfg_valid", cfg_valid, 0);
    check_status("rst");
    tick(1);
    reset = 1'b0;
    tick(8);

    // Single lane DAC write with latency check; ready held low so tvalid stays observable.
    tr_mode = 1;
    w = '{24'h1ABCDE, 24'h0, 24'h0, 24'h0};
    send(w, 24);
    repeat (3) @(posedge a_clk);
    @(negedge a_clk);
    check("lat_tvalid_early", tvalid[0], 1'b0);
    @(posedge a_clk);
    @(negedge a_clk);
    check("lat_tvalid", tvalid[0], 1'b1);
    check("lat_tdata", tdata[0], 32'hABCDE000);
    tr_mode = 2;
    tick(12);
    check_status("t1");

    // Mixed DAC/config lanes in one frame.
    tr_mode = 0;
    w = '{24'h100000, 24'h1FFFFF, 24'h280000, 24'h200012};
    send(w, 24);
    tick(14);
    check("t2_cfg_lane2", cfg_word[71:48], 24'h280000);
    check("t2_cfg_lane3", cfg_word[95:72], 24'h200012);
    check_status("t2");

    // Short frame.
    w = '{24'h1ABCDE, 24'h1ABCDE, 24'h1ABCDE, 24'h1ABCDE};
    send(w, 23);
    tick(14);
    check("t3_tvalid", tvalid, 0);
    check_status("t3");
    pulse_clear();
    check_status("t3_clr");

    // Overrun with ready held low, then release.
    tr_mode = 1;
    w = '{24'h100001, 24'h0, 24'h0, 24'h0};
    send(w, 24);
    tick(14);
    w = '{24'h100002, 24'h0, 24'h0, 24'h0};
    send(w, 24);
    tick(14);
    check("t4_tdata", tdata[0], 32'h00002000);
    check("t4_overrun", overrun, 1'b1);
    tr_mode = 2;
    @(posedge a_clk);
    @(negedge a_clk);
    check("t4_accept_tvalid", tvalid[0], 1'b1);
    @(posedge a_clk);
    @(negedge a_clk);
    check("t4_tvalid_drop", tvalid[0], 1'b0);
    check_status("t4");
    pulse_clear();

    // Reset in the middle of a frame.
    tick(4);
    w = '{24'h1FFFFF, 24'h1FFFFF, 24'h1FFFFF, 24'h1FFFFF};
    syncn = 1'b0;
    tick(2);
    drive_bits(w, 0, 10);
    reset = 1'b1;
    tick(3);
    model_reset();
    @(negedge a_clk);
    check("t5_rst_tvalid", tvalid, 0);
    check("t5_rst_cfg", cfg_word, 0);
    tick(1);
    reset = 1'b0;
    drive_bits(w, 10, 14);
    syncn = 1'b1;
    tick(14);
    check_status("t5_discard");
    w = '{24'h155555, 24'h0, 24'h0, 24'h0};
    send(w, 24);
    tick(14);
    check_status("t5");

    // Randomized frames.
    tr_mode = 0;
    for (int f = 0; f < 30; f++) begin
      int nb;
      for (int l = 0; l < NL; l++)
        w[l] = ($urandom % 5 < 3) ? {4'b0001, 20'($urandom)} : 24'($urandom);
      nb = ($urandom % 8 == 0) ? int'($urandom_range(1, 30)) : 24;
      send(w, nb);
      tick(14);
      check_status($sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
